alu_core: RTL and testbench
===========================

ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have port CLOCK, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET, input, 1 bit; reset is asynchronous and active-high.
REQ-003 SHALL have port A, input, 32 bits; first operand.
REQ-004 SHALL have port B, input, 32 bits; second operand; B[4:0] is the shift amount for shift operations.
REQ-005 SHALL have port ALU_control, input, 4 bits; operation select.
REQ-006 SHALL have port valid_in, input, 1 bit; operands and ALU_control are valid this cycle.
REQ-007 SHALL have port ALU_result, output, 32 bits; registered result.
REQ-008 SHALL have port zero, output, 1 bit; registered flag, high when ALU_result is all zeros.
REQ-009 SHALL have port valid_out, output, 1 bit; ALU_result and zero hold a fresh result this cycle.

Function
REQ-010 SHALL decode ALU_control as follows:
- 0000 ADD: A+B
- 0001 SUB: A-B
- 0010 AND: A&B
- 0011 OR: A|B
- 0100 XOR: A^B
REQ-011 SHALL decode ALU_control as follows:
- 0101 SLL: A<<B[4:0]
- 0110 SRL: logical A>>B[4:0]
- 0111 SRA: arithmetic A>>>B[4:0], sign-filled from A[31]
REQ-012 SHALL decode ALU_control as follows:
- 1000 SLTU: 1 if A<B unsigned, else 0
- 1001 SLT: 1 if A<B two's-complement signed, else 0
- result zero-extended to 32 bits
REQ-013 SHALL produce a result of 0 for ALU_control codes 1010-1111.
REQ-014 SHALL wrap ADD/SUB modulo 2^32 with no saturation; carry and overflow are discarded.
REQ-015 SHALL ignore B[31:5] for shifts; shift by 0 returns A unchanged.
REQ-016 SHALL register the result and zero flag on the rising CLOCK edge when valid_in=1, giving exactly one cycle of latency.
REQ-017 SHALL drive valid_out to the value of valid_in from the previous cycle.
REQ-018 SHALL hold ALU_result and zero unchanged while valid_in=0.
REQ-019 SHALL compute zero from the same 32-bit value that is loaded into ALU_result.
REQ-020 SHALL accept back-to-back operations every cycle with no stall.

Reset
REQ-021 SHALL force ALU_result=0, zero=1 and valid_out=0 immediately while RESET is high, independent of CLOCK.
REQ-022 SHALL discard an operation presented in the cycle RESET is asserted.
REQ-023 SHALL capture the first operation on the first rising edge after RESET deasserts.

Configuration
REQ-024 SHALL add outputs carry (1 bit), overflow (1 bit) and negative (1 bit) when macro ALU_FLAGS_EN is defined. These outputs:
- are registered alongside ALU_result and reset to 0
- carry: carry-out of ADD, or NOT borrow for SUB
- overflow: signed overflow of ADD/SUB
- negative: ALU_result[31]
- carry and overflow are 0 for all other operations
REQ-025 SHALL omit these ports and their logic entirely when ALU_FLAGS_EN is not defined.

Structure
REQ-026 SHALL place the following in shared package alu_pkg:
- a 4-bit enum type for the ALU_control opcodes: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLTU, OP_SLT
- constant XLEN=32
REQ-027 SHALL implement the combinational datapath as sub-module alu_comb. The top level alu_core holds only the output registers and the valid pipeline.

Verification
REQ-028 SHALL check ADD: A=0x7FFFFFFF, B=1, ALU_control=0000, valid_in=1 -> next cycle ALU_result=0x80000000, zero=0, valid_out=1. With ALU_FLAGS_EN defined, overflow=1.
REQ-029 SHALL check SUB: A=5, B=5, ALU_control=0001 -> ALU_result=0, zero=1.
REQ-030 SHALL check shifts:
- SRA: A=0x80000000, B=0x00000024 (shift 4) -> 0xF8000000
- SRL with the same operands -> 0x08000000
- SLL: A=1, B=31 -> 0x80000000
REQ-031 SHALL check compares with A=0xFFFFFFFF, B=1:
- SLT (1001) -> 1
- SLTU (1000) -> 0
REQ-032 SHALL check logic ops: A=0xF0F0F0F0, B=0xFF00FF00 -> AND 0xF000F000, OR 0xFFF0FFF0, XOR 0x0FF00FF0. Code 1111 -> 0 with zero=1.
REQ-033 SHALL check reset and hold:
- assert RESET mid-stream -> outputs 0/zero=1/valid_out=0 immediately, without waiting for a clock edge
- with valid_in=0, ALU_result is held

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU core.
//   XLEN     : datapath width (32)
//   alu_op_e : 4-bit opcode carried on ALU_control; codes 1010-1111 are
//              unassigned and produce a zero result.
// Optional feature macro: ALU_FLAGS_EN (carry/overflow/negative flags).
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SLT  = 4'b1001
  } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// alu_comb -- purely combinational ALU datapath.
// Ports:
//   a, b       : operands (b[4:0] is the shift amount for shifts)
//   op         : operation select (alu_op_e encoding)
//   result     : XLEN-bit result
//   carry      : carry-out of ADD / NOT borrow of SUB   (ALU_FLAGS_EN only)
//   overflow   : signed overflow of ADD/SUB            (ALU_FLAGS_EN only)
// Optional feature macro: ALU_FLAGS_EN.
module alu_comb
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
`ifdef ALU_FLAGS_EN
  output logic            carry,
  output logic            overflow,
`endif
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  // Main result mux; unassigned opcodes fall through to zero.
  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [XLEN:0] addWide;
  logic [XLEN:0] subWide;

  // Subtraction is done as a + ~b + 1 so that the top bit is NOT borrow.
  assign addWide = {1'b0, a} + {1'b0, b};
  assign subWide = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};

  // Flags only mean something for ADD/SUB; every other op reports 0.
  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        carry    = addWide[XLEN];
        overflow = (a[XLEN-1] == b[XLEN-1]) && (addWide[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB: begin
        carry    = subWide[XLEN];
        overflow = (a[XLEN-1] != b[XLEN-1]) && (subWide[XLEN-1] != a[XLEN-1]);
      end
      default: begin
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end
`endif

endmodule

// File: rtl/alu_core.sv
// alu_core -- registered ALU with one cycle of latency.
// Ports:
//   CLOCK, RESET   : clock; asynchronous active-high reset
//   A, B           : operands (B[4:0] = shift amount)
//   ALU_control    : opcode (alu_op_e encoding)
//   valid_in       : operands/opcode valid this cycle
//   ALU_result     : registered result, held while valid_in is low
//   zero           : registered flag, ALU_result == 0
//   valid_out      : valid_in delayed by one cycle
//   carry, overflow, negative : registered flags (ALU_FLAGS_EN only)
// Optional feature macro: ALU_FLAGS_EN.
module alu_core
  import alu_pkg::*;
(
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      ALU_control,
  input  logic            valid_in,
`ifdef ALU_FLAGS_EN
  output logic            carry,
  output logic            overflow,
  output logic            negative,
`endif
  output logic [XLEN-1:0] ALU_result,
  output logic            zero,
  output logic            valid_out
);

  logic [XLEN-1:0] combResult;
  logic [XLEN-1:0] result_d, result_q;
  logic            zero_d, zero_q;
  logic            valid_q;

`ifdef ALU_FLAGS_EN
  logic combCarry, combOverflow;
  logic carry_d, carry_q;
  logic overflow_d, overflow_q;
  logic negative_d, negative_q;
`endif

  alu_comb u_alu_comb (
    .a        (A),
    .b        (B),
    .op       (ALU_control),
`ifdef ALU_FLAGS_EN
    .carry    (combCarry),
    .overflow (combOverflow),
`endif
    .result   (combResult)
  );

  // Load a new result only on valid cycles; zero is derived from the very
  // value being loaded so the two can never disagree.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    if (valid_in) begin
      result_d = combResult;
      zero_d   = (combResult == '0);
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_in;
    end
  end

`ifdef ALU_FLAGS_EN
  always_comb begin
    carry_d    = carry_q;
    overflow_d = overflow_q;
    negative_d = negative_q;
    if (valid_in) begin
      carry_d    = combCarry;
      overflow_d = combOverflow;
      negative_d = combResult[XLEN-1];
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      negative_q <= negative_d;
    end
  end

  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign negative = negative_q;
`endif

  assign ALU_result = result_q;
  assign zero       = zero_q;
  assign valid_out  = valid_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core -- self-checking bench for alu_core.
// Expected results are pushed to a scoreboard queue as each operation is
// driven and popped when the registered output appears one cycle later.
// Honours ALU_FLAGS_EN when the macro is defined for the build.
module tb_alu_core;

  logic        CLOCK;
  logic        RESET;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_control;
  logic        valid_in;
  logic [31:0] ALU_result;
  logic        zero;
  logic        valid_out;
`ifdef ALU_FLAGS_EN
  logic        carry;
  logic        overflow;
  logic        negative;
`endif

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        negative;
  } expect_t;

  expect_t     scoreboard[$];
  int          vectorCount;
  int          failCount;
  logic [31:0] lastResult;
  logic        lastZero;

  alu_core dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .A           (A),
    .B           (B),
    .ALU_control (ALU_control),
    .valid_in    (valid_in),
`ifdef ALU_FLAGS_EN
    .carry       (carry),
    .overflow    (overflow),
    .negative    (negative),
`endif
    .ALU_result  (ALU_result),
    .zero        (zero),
    .valid_out   (valid_out)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Reference model written independently of the RTL: shifts as bit loops,
  // signed compare from the sign bits.
  function automatic expect_t modelAlu(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    expect_t     e;
    logic [31:0] r;
    logic [32:0] wide;
    int          sh;
    e  = '0;
    r  = '0;
    sh = int'(b[4:0]);
    case (op)
      4'd0: begin
        wide       = {1'b0, a} + {1'b0, b};
        r          = wide[31:0];
        e.carry    = wide[32];
        e.overflow = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        r          = a - b;
        e.carry    = (a >= b);
        e.overflow = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin r = a; for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0}; end
      4'd6: begin r = a; for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]}; end
      4'd7: begin r = a; for (int i = 0; i < sh; i++) r = {r[31], r[31:1]}; end
      4'd8: r = {31'd0, (a < b)};
      4'd9: r = {31'd0, (a[31] != b[31]) ? a[31] : (a < b)};
      default: r = '0;
    endcase
    e.result   = r;
    e.zero     = (r == 32'd0);
    e.negative = r[31];
    return e;
  endfunction

  // Drive one valid operation (optionally on the next falling edge) and
  // queue its expected result, which must match the stated constant.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expRes,
                               input bit waitEdge);
    expect_t e;
    if (waitEdge) @(negedge CLOCK);
    A           = a;
    B           = b;
    ALU_control = op;
    valid_in    = 1'b1;
    e           = modelAlu(op, a, b);
    e.result    = expRes;
    e.zero      = (expRes == 32'd0);
    e.negative  = expRes[31];
    scoreboard.push_back(e);
  endtask

  task automatic compareBit(input string tag, input logic observed, input logic expected);
    vectorCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  task automatic compareWord(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // After the next rising edge, the oldest queued operation must be on the outputs.
  task automatic checkOutput(input string tag);
    expect_t e;
    @(posedge CLOCK);
    #1;
    compareBit({tag, ".valid_out"}, valid_out, 1'b1);
    vectorCount++;
    assert (scoreboard.size() > 0) else begin
      failCount++;
      $error("[TB] FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      compareWord({tag, ".result"}, ALU_result, e.result);
      compareBit({tag, ".zero"}, zero, e.zero);
`ifdef ALU_FLAGS_EN
      compareBit({tag, ".carry"}, carry, e.carry);
      compareBit({tag, ".overflow"}, overflow, e.overflow);
      compareBit({tag, ".negative"}, negative, e.negative);
`endif
      lastResult = e.result;
      lastZero   = e.zero;
    end
  endtask

  task automatic checkReset(input string tag);
    compareWord({tag, ".result"}, ALU_result, 32'd0);
    compareBit({tag, ".zero"}, zero, 1'b1);
    compareBit({tag, ".valid_out"}, valid_out, 1'b0);
`ifdef ALU_FLAGS_EN
    compareBit({tag, ".carry"}, carry, 1'b0);
    compareBit({tag, ".overflow"}, overflow, 1'b0);
    compareBit({tag, ".negative"}, negative, 1'b0);
`endif
  endtask

  initial begin
    expect_t     e;
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    vectorCount = 0;
    failCount   = 0;
    lastResult  = '0;
    lastZero    = 1'b1;
    RESET       = 1'b1;
    valid_in    = 1'b0;
    A           = '0;
    B           = '0;
    ALU_control = '0;
    #1;
    checkReset("reset_initial");
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;

    // Directed vectors, back to back with valid_in held high.
    applyStimulus(4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
    checkOutput("add_ovf");
    applyStimulus(4'b0001, 32'd5, 32'd5, 32'd0, 1'b1);
    checkOutput("sub_zero");
    applyStimulus(4'b0111, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b1);
    checkOutput("sra");
    applyStimulus(4'b0110, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b1);
    checkOutput("srl");
    applyStimulus(4'b0101, 32'h1, 32'd31, 32'h8000_0000, 1'b1);
    checkOutput("sll");
    applyStimulus(4'b0101, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b1);
    checkOutput("sll_by0");
    applyStimulus(4'b1001, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1);
    checkOutput("slt");
    applyStimulus(4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    checkOutput("sltu");
    applyStimulus(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1);
    checkOutput("and");
    applyStimulus(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b1);
    checkOutput("or");
    applyStimulus(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1);
    checkOutput("xor");
    applyStimulus(4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 1'b1);
    checkOutput("op_1111");
    applyStimulus(4'b0000, 32'hFFFF_FFFF, 32'h2, 32'h1, 1'b1);
    checkOutput("add_wrap");
    applyStimulus(4'b0001, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1);
    checkOutput("sub_wrap");

    // Random vectors checked against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 4'($urandom_range(0, 15));
      e   = modelAlu(rop, ra, rb);
      applyStimulus(rop, ra, rb, e.result, 1'b1);
      checkOutput("random");
    end

    // Hold: with valid_in low the outputs keep the last result.
    applyStimulus(4'b0000, 32'd100, 32'd23, 32'd123, 1'b1);
    checkOutput("pre_hold");
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      valid_in    = 1'b0;
      A           = $urandom;
      B           = $urandom;
      ALU_control = 4'b0001;
      @(posedge CLOCK);
      #1;
      compareBit("hold.valid_out", valid_out, 1'b0);
      compareWord("hold.result", ALU_result, lastResult);
      compareBit("hold.zero", zero, lastZero);
    end

    // Reset mid-stream: outputs clear before any clock edge, and the
    // operation presented while RESET is high is discarded.
    applyStimulus(4'b0011, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b1);
    checkOutput("pre_reset");
    applyStimulus(4'b0000, 32'd7, 32'd8, 32'd15, 1'b1);
    #2;
    RESET = 1'b1;
    #1;
    checkReset("reset_async");
    scoreboard.delete();
    @(posedge CLOCK);
    #1;
    checkReset("reset_held");

    // First operation captured on the first edge after RESET falls.
    @(negedge CLOCK);
    RESET = 1'b0;
    applyStimulus(4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
    checkOutput("post_reset");
    @(negedge CLOCK);
    valid_in = 1'b0;
    @(posedge CLOCK);
    #1;
    compareBit("drain.valid_out", valid_out, 1'b0);
    compareWord("drain.result", ALU_result, 32'h5555_5555);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
